// File: rtl/data_mem_defs.sv
// rtl/data_mem_defs.sv - shared state encodings and constants for the data-memory responder
package data_mem_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int LANE_WIDTH          = 8;
   localparam int BYTE_LANES          = 4;
   localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word storage with byte-lane writes, combinational read, synchronous clear
module mem_array
   import data_mem_defs::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             write_en,
   input  logic [ADDR_WIDTH-1:0]            word_addr,
   input  logic [BYTE_LANES-1:0]            byte_en,
   input  logic [BYTE_LANES*LANE_WIDTH-1:0] write_data,
   output logic [BYTE_LANES*LANE_WIDTH-1:0] read_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [BYTE_LANES*LANE_WIDTH-1:0] words [DEPTH];

   // Clear every word on reset, otherwise update only the enabled lanes
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            words[i] <= '0;
         end
      end else if (write_en) begin
         for (int lane = 0; lane < BYTE_LANES; lane++) begin
            if (byte_en[lane]) begin
               words[word_addr][lane*LANE_WIDTH +: LANE_WIDTH] <= write_data[lane*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   assign read_data = words[word_addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - req/ack data memory with wait states; DATA_MEM_RANGE_CHECK_EN enables out-of-range errors
module data_mem_responder
   import data_mem_defs::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   input  logic [3:0]  byte_en,
   output logic        ack,
   output logic [31:0] data_out,
   output logic        error
);

   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      state, state_next;
   logic [3:0]  counter, counter_next;

   logic [31:0] cap_address;
   logic        cap_we;
   logic [31:0] cap_data;
   logic [3:0]  cap_byte_en;

   // With zero wait states RESP is entered on the capture edge itself, so the
   // access is decoded from the live inputs while in IDLE and from the copy otherwise.
   logic [31:0] acc_address;
   logic        acc_we;
   logic [31:0] acc_data;
   logic [3:0]  acc_byte_en;
   logic        misaligned;
   logic        out_of_range;
   logic        acc_error;
   logic        enter_resp;
   logic        mem_write;
   logic [31:0] read_data;

   assign acc_address = (state == IDLE) ? address : cap_address;
   assign acc_we      = (state == IDLE) ? we      : cap_we;
   assign acc_data    = (state == IDLE) ? data_in : cap_data;
   assign acc_byte_en = (state == IDLE) ? byte_en : cap_byte_en;

   assign misaligned = |acc_address[1:0];

`ifdef DATA_MEM_RANGE_CHECK_EN
   assign out_of_range = |acc_address[31:ADDR_WIDTH+2];
`else
   // Upper address bits are don't-care: the address wraps modulo the depth.
   logic unused_upper;
   assign unused_upper = ^acc_address[31:ADDR_WIDTH+2];
   assign out_of_range = 1'b0;
`endif

   assign acc_error  = misaligned | out_of_range;
   assign enter_resp = (state_next == RESP) && (state != RESP);
   assign mem_write  = enter_resp && acc_we && !acc_error;
   assign ack        = (state == RESP);

   mem_array #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_mem_array (
      .clock     (clock),
      .reset     (reset),
      .write_en  (mem_write),
      .word_addr (acc_address[ADDR_WIDTH+1:2]),
      .byte_en   (acc_byte_en),
      .write_data(acc_data),
      .read_data (read_data)
   );

   // Next-state and wait-counter decode
   always_comb begin
      state_next   = state;
      counter_next = counter;
      case (state)
         IDLE: begin
            if (req) begin
               if (WAIT_CYCLES == 0) begin
                  state_next = RESP;
               end else begin
                  state_next   = WAIT;
                  counter_next = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (counter == 4'd0) begin
               state_next = RESP;
            end else begin
               counter_next = counter - 4'd1;
            end
         end
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, counter, request capture and response registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         counter     <= 4'd0;
         cap_address <= '0;
         cap_we      <= 1'b0;
         cap_data    <= '0;
         cap_byte_en <= '0;
         error       <= 1'b0;
         data_out    <= '0;
      end else begin
         state   <= state_next;
         counter <= counter_next;
         if (state == IDLE && req) begin
            cap_address <= address;
            cap_we      <= we;
            cap_data    <= data_in;
            cap_byte_en <= byte_en;
         end
         if (enter_resp) begin
            error <= acc_error;
            if (acc_error) begin
               data_out <= '0;
            end else if (!acc_we) begin
               data_out <= read_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder (2 and 0 wait states)
module tb_data_mem_responder;

   logic        clock = 1'b0;
   logic        reset, req, we;
   logic [31:0] address, data_in;
   logic [3:0]  byte_en;
   logic        ack, error;
   logic [31:0] data_out;

   logic        reset0, req0, we0;
   logic [31:0] address0, data_in0;
   logic [3:0]  byte_en0;
   logic        ack0, error0;
   logic [31:0] data_out0;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
      .clock(clock), .reset(reset), .req(req), .we(we), .address(address),
      .data_in(data_in), .byte_en(byte_en), .ack(ack), .data_out(data_out), .error(error)
   );

   data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
      .clock(clock), .reset(reset0), .req(req0), .we(we0), .address(address0),
      .data_in(data_in0), .byte_en(byte_en0), .ack(ack0), .data_out(data_out0), .error(error0)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One request on the 2-wait-state DUT; returns at the negedge inside the ack cycle.
   task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input string tag);
      int lat;
      @(negedge clock);
      req = 1'b1; we = w; address = a; data_in = d; byte_en = be;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!ack && lat < 20);
      req = 1'b0;
      check({tag, " latency"}, 32'(lat), 32'd3);
   endtask

   initial begin
      int stray_acks;
      reset = 1'b1; req = 1'b0; we = 1'b0; address = '0; data_in = '0; byte_en = '0;
      reset0 = 1'b1; req0 = 1'b0; we0 = 1'b0; address0 = '0; data_in0 = '0; byte_en0 = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0; reset0 = 1'b0;

      check("reset ack", 32'(ack), 32'd0);
      check("reset error", 32'(error), 32'd0);
      check("reset data_out", data_out, 32'd0);

      xact(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, "store 0x10");
      check("store 0x10 error", 32'(error), 32'd0);
      xact(1'b0, 32'h10, 32'h0, 4'b0000, "load 0x10");
      check("load 0x10 data", data_out, 32'hDEADBEEF);
      check("load 0x10 error", 32'(error), 32'd0);

      xact(1'b1, 32'h20, 32'h11223344, 4'b1111, "store 0x20 full");
      xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "store 0x20 partial");
      check("store keeps data_out", data_out, 32'hDEADBEEF);
      check("partial store error", 32'(error), 32'd0);
      xact(1'b0, 32'h20, 32'h0, 4'b0000, "load 0x20");
      check("load 0x20 merged", data_out, 32'h11BB33DD);

      xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, "store no lanes");
      check("no-lane store error", 32'(error), 32'd0);
      xact(1'b0, 32'h20, 32'h0, 4'b0000, "load after no-lane");
      check("no-lane store no effect", data_out, 32'h11BB33DD);

      xact(1'b0, 32'h22, 32'h0, 4'b0000, "load 0x22");
      check("misaligned load error", 32'(error), 32'd1);
      check("misaligned load data", data_out, 32'd0);
      xact(1'b1, 32'h21, 32'h99999999, 4'b1111, "store 0x21");
      check("misaligned store error", 32'(error), 32'd1);
      xact(1'b0, 32'h20, 32'h0, 4'b0000, "reload 0x20");
      check("0x20 untouched", data_out, 32'h11BB33DD);
      check("reload 0x20 error", 32'(error), 32'd0);

      xact(1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, "store 0x0");
      xact(1'b0, 32'h400, 32'h0, 4'b0000, "load 0x400");
`ifdef DATA_MEM_RANGE_CHECK_EN
      check("0x400 error", 32'(error), 32'd1);
      check("0x400 data", data_out, 32'd0);
`else
      check("0x400 error", 32'(error), 32'd0);
      check("0x400 wraps", data_out, 32'hCAFEF00D);
`endif

      // Reset during the wait phase of a store
      @(negedge clock);
      req = 1'b1; we = 1'b1; address = 32'h30; data_in = 32'h55AA55AA; byte_en = 4'b1111;
      @(negedge clock);
      req = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("post-reset ack", 32'(ack), 32'd0);
      check("post-reset error", 32'(error), 32'd0);
      check("post-reset data_out", data_out, 32'd0);
      stray_acks = 0;
      repeat (6) begin
         @(negedge clock);
         if (ack) stray_acks++;
      end
      check("no ack for aborted store", 32'(stray_acks), 32'd0);
      xact(1'b0, 32'h30, 32'h0, 4'b0000, "load 0x30");
      check("aborted store not written", data_out, 32'd0);

      // Zero wait states with req held high: one ack every second cycle
      @(negedge clock);
      req0 = 1'b1; we0 = 1'b1; byte_en0 = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         address0 = 32'(k * 4); data_in0 = 32'h10000000 + 32'(k);
         @(negedge clock);
         check($sformatf("w0 store %0d ack", k), 32'(ack0), 32'd1);
         @(negedge clock);
         check($sformatf("w0 store %0d gap", k), 32'(ack0), 32'd0);
      end
      we0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         address0 = 32'(k * 4);
         @(negedge clock);
         check($sformatf("w0 load %0d ack", k), 32'(ack0), 32'd1);
         check($sformatf("w0 load %0d data", k), data_out0, 32'h10000000 + 32'(k));
         check($sformatf("w0 load %0d error", k), 32'(error0), 32'd0);
         @(negedge clock);
         check($sformatf("w0 load %0d gap", k), 32'(ack0), 32'd0);
      end
      req0 = 1'b0;
      repeat (2) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
